// File: rtl/vga_timing_gen.sv
//------------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing generator for 640x480@60 VGA (parameterisable geometry).
// Free-running horizontal/vertical counters drive the pixel coordinates, and
// registered decodes of those coordinates drive the display-enable and sync
// flags. Every flag register is loaded from a decode of the *next* counter
// value, so flags and coordinates change on the same edge with zero skew.
//
// Optional feature (macro PIXEL_DIV_EN):
//   defined   - an internal toggle flop divides clk by two; pix_en is that
//               flop and every pixel lasts two clk cycles (50 MHz board clock).
//   undefined - no divider; pix_en is tied high and counters advance each clk.
//
// Ports:
//   clk          in   system clock (pixel clock, or 2x pixel clock with divider)
//   rst_n        in   asynchronous active-low reset
//   pix_en       out  pixel advance strobe
//   hsync        out  horizontal sync, asserted level = SYNC_POL
//   vsync        out  vertical sync, asserted level = SYNC_POL
//   Hdisplay     out  1 while x < H_ACTIVE
//   Vdisplay     out  1 while y < V_ACTIVE
//   x            out  current horizontal count
//   y            out  current vertical count
//   line_start   out  1 for the pixel period where x == 0
//   frame_start  out  1 for the pixel period where x == 0 and y == 0
//------------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0,
    parameter int   CNT_W    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             pix_en,
    output logic             hsync,
    output logic             vsync,
    output logic             Hdisplay,
    output logic             Vdisplay,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEGIN  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEGIN  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic SYNC_ON  = SYNC_POL;
    localparam logic SYNC_OFF = ~SYNC_POL;

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;

    logic hd_q, vd_q, hs_q, vs_q, ls_q, fs_q;
    logic hd_nxt, vd_nxt, hs_nxt, vs_nxt, ls_nxt, fs_nxt;

    //--------------------------------------------------------------------------
    // Pixel-clock divider
    //--------------------------------------------------------------------------
`ifdef PIXEL_DIV_EN
    logic div_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= 1'b0;
        end else begin
            div_q <= ~div_q;
        end
    end

    assign pix_en = div_q;
`else
    assign pix_en = 1'b1;
`endif

    //--------------------------------------------------------------------------
    // Next counter position. Line wrap and frame wrap resolve in one update.
    //--------------------------------------------------------------------------
    always_comb begin
        h_nxt = h_cnt;
        v_nxt = v_cnt;
        if (h_cnt == H_LAST) begin
            h_nxt = '0;
            if (v_cnt == V_LAST) begin
                v_nxt = '0;
            end else begin
                v_nxt = v_cnt + 1'b1;
            end
        end else begin
            h_nxt = h_cnt + 1'b1;
        end
    end

    //--------------------------------------------------------------------------
    // Flag decodes of the next position, so the registered flags line up with
    // the registered coordinates. vsync only moves when v_nxt moves, which is
    // on the line-wrap edge.
    //--------------------------------------------------------------------------
    always_comb begin
        hd_nxt = (h_nxt < H_ACT_END);
        vd_nxt = (v_nxt < V_ACT_END);
        hs_nxt = ((h_nxt >= HS_BEGIN) && (h_nxt < HS_END)) ? SYNC_ON : SYNC_OFF;
        vs_nxt = ((v_nxt >= VS_BEGIN) && (v_nxt < VS_END)) ? SYNC_ON : SYNC_OFF;
        ls_nxt = (h_nxt == '0);
        fs_nxt = (h_nxt == '0) && (v_nxt == '0);
    end

    //--------------------------------------------------------------------------
    // Counter and flag registers. Reset parks the raster on the last pixel of
    // the frame so the first advance lands cleanly on (0,0).
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= H_LAST;
            v_cnt <= V_LAST;
            hd_q  <= 1'b0;
            vd_q  <= 1'b0;
            hs_q  <= SYNC_OFF;
            vs_q  <= SYNC_OFF;
            ls_q  <= 1'b0;
            fs_q  <= 1'b0;
        end else if (pix_en) begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
            hd_q  <= hd_nxt;
            vd_q  <= vd_nxt;
            hs_q  <= hs_nxt;
            vs_q  <= vs_nxt;
            ls_q  <= ls_nxt;
            fs_q  <= fs_nxt;
        end
    end

    assign x           = h_cnt;
    assign y           = v_cnt;
    assign Hdisplay    = hd_q;
    assign Vdisplay    = vd_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 VGA raster timing.
- Drives the per-pixel display stage:
  - display-enable flags Hdisplay and Vdisplay;
  - pixel coordinates x and y, consumed by the ball/bar/points/win-letter hit logic;
  - hsync and vsync, which go to the connector.
- Free-running horizontal and vertical counters, with optional internal pixel-clock division.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)
- CNT_W, 10, counter and coordinate width; must satisfy 2^CNT_W >= H_TOTAL and >= V_TOTAL

Ports:
- clk  in  1  system clock (25 MHz pixel clock, or 50 MHz with PIXEL_DIV_EN)
- rst_n  in  1  asynchronous active-low reset
- pix_en  out  1  pixel advance strobe; constant 1 without PIXEL_DIV_EN
- hsync  out  1  horizontal sync to connector
- vsync  out  1  vertical sync to connector
- Hdisplay  out  1  1 while x < H_ACTIVE
- Vdisplay  out  1  1 while y < V_ACTIVE
- x  out  CNT_W  current horizontal count
- y  out  CNT_W  current vertical count
- line_start  out  1  1 for the pixel period where x == 0
- frame_start  out  1  1 for the pixel period where x == 0 and y == 0

Behaviour:
- Derived totals:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP (800).
  - V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP (525).
- Line order: active, front porch, sync, back porch. Frame order is the same.
- Counters advance on rising clk edges where pix_en == 1.
  - h_cnt: 0..H_TOTAL-1.
  - At h_cnt == H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - At h_cnt == H_TOTAL-1 and v_cnt == V_TOTAL-1, both counters wrap to 0 on the same edge.
- x = h_cnt and y = v_cnt, driven directly from the counter registers.
- All flag outputs are registered and aligned with x/y: in any cycle, every flag decodes the current x/y. Zero cycles of skew between coordinates and flags.
- Flag decodes:
  - Hdisplay = (x < H_ACTIVE); Vdisplay = (y < V_ACTIVE).
  - hsync = SYNC_POL when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751); otherwise ~SYNC_POL.
  - vsync = SYNC_POL when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491); otherwise ~SYNC_POL.
  - vsync changes only on the edge where the line wraps.
- Reset (rst_n low, asynchronous, any time including mid-frame):
  - h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1, so x = 799 and y = 524.
  - Hdisplay = 0, Vdisplay = 0.
  - hsync = vsync = ~SYNC_POL.
  - line_start = 0, frame_start = 0.
  - Divider flop = 0.
- First counter advance after rst_n rises moves to (0,0), with Hdisplay = Vdisplay = 1 and line_start = frame_start = 1. Output therefore always starts on a clean frame boundary.
- No simultaneous-event ambiguity: line wrap and frame wrap are a single update on one edge.
- Outputs are held (not cleared) on edges where pix_en == 0.
- The downstream display stage registers colour one clk after Hdisplay/Vdisplay. The top level delays hsync/vsync by one pixel to match; this block does not.

Optional Feature:
- Macro: PIXEL_DIV_EN.
- Defined:
  - Internal toggle flop, reset 0, inverts every clk.
  - pix_en = toggle flop value.
  - Counters and flag registers update only on edges where pix_en == 1, so each pixel lasts 2 clk. This supports a 50 MHz board clock.
  - line_start and frame_start are high for 2 clk.
  - First advance occurs on the 2nd rising edge after reset release.
- Undefined:
  - No divider flop; pix_en tied to 1.
  - Counters advance every clk; first advance on the 1st edge after reset release.

Test Plan:
- Reset, no div: hold rst_n = 0 → x = 799, y = 524, Hdisplay = Vdisplay = 0, hsync = vsync = 1, frame_start = 0. Release → next edge gives x = 0, y = 0, frame_start = 1, Hdisplay = Vdisplay = 1.
- Line timing: run one line → Hdisplay high exactly 640 clk; hsync low exactly for x = 656..751 (96 clk); line period 800 clk; line_start one clk wide.
- Frame timing: run 2 frames → Vdisplay high for 480 lines; vsync low for y = 490..491 (1600 clk); frame_start period exactly 420000 clk; y wraps 524 → 0 together with x 799 → 0.
- Async reset mid-frame: assert rst_n at x = 300, y = 200 → outputs take reset values immediately, without a clk edge. Release → restart at (0,0) with frame_start = 1.
- PIXEL_DIV_EN defined: pix_en alternates 0/1; x increments every 2 clk; frame_start high 2 clk; frame period 840000 clk; hsync low 192 clk.
- Coordinate/flag alignment: at every clk, check Hdisplay == (x < 640), Vdisplay == (y < 480) and the hsync/vsync decodes above against a reference counter model over a full frame.
